// File: rtl/lcd_fb_writer_if.sv
// PPU pixel stream into the framebuffer writer, plus its framebuffer write
// port and frame status back out.
interface lcd_fb_writer_if;
    logic        lcd_pixel;
    logic [1:0]  lcd_color;
    logic        lcd_hsync;
    logic        lcd_vsync;
    logic [7:0]  bgp;
    logic [13:0] fb_addr;
    logic [7:0]  fb_data;
    logic        fb_we;
    logic        frame_ready;
    logic        display_bank;
    logic        line_err;

    // PPU / scan-out side: drives the pixel stream, consumes writes and status
    modport master (
        output lcd_pixel, lcd_color, lcd_hsync, lcd_vsync, bgp,
        input  fb_addr, fb_data, fb_we, frame_ready, display_bank, line_err
    );

    // Framebuffer writer side
    modport slave (
        input  lcd_pixel, lcd_color, lcd_hsync, lcd_vsync, bgp,
        output fb_addr, fb_data, fb_we, frame_ready, display_bank, line_err
    );
endinterface

// File: rtl/lcd_fb_writer.sv
// Captures the PPU pixel stream, maps colour indices through BGP, packs four
// shades per byte and writes them into a double-buffered framebuffer. A bank
// is only handed to scan-out once a full, well-formed frame has landed in it.
module lcd_fb_writer #(
    parameter int H_PIX          = 160,
    parameter int V_LINES        = 144,
    parameter int BYTES_PER_LINE = H_PIX / 4
) (
    input  logic           clk,
    input  logic           rst,
    lcd_fb_writer_if.slave bus
);
    localparam int XW = $clog2(H_PIX + 1);
    localparam int YW = $clog2(V_LINES + 2);
    localparam int OW = 13;

    localparam logic [XW-1:0] X_END  = XW'(H_PIX);
    localparam logic [YW-1:0] Y_END  = YW'(V_LINES);
    localparam logic [OW-1:0] STRIDE = OW'(BYTES_PER_LINE);

    typedef enum logic [1:0] {S_SYNC, S_ACTIVE, S_HBLANK, S_VBLANK} state_t;

    state_t        state;
    state_t        state_next;

    logic          hsync_q;
    logic          vsync_q;
    logic          vsync_seen;
    logic [XW-1:0] x;
    logic [YW-1:0] y;
    logic [OW-1:0] line_base;
    logic          frame_bad;
    logic          line_ovf;
    logic          wr_bank;
    logic [5:0]    pack;

    logic          hs_rise;
    logic          hs_fall;
    logic          vs_rise;
    logic          vs_fall;
    logic [1:0]    shade;
    logic          accept;
    logic          line_end;
    logic          frame_end;
    logic          frame_start;
    logic          pix_keep;
    logic          byte_done;
    logic          line_bad;
    logic [YW-1:0] y_after;
    logic          frame_ok;

    assign hs_rise = bus.lcd_hsync & ~hsync_q;
    assign hs_fall = ~bus.lcd_hsync & hsync_q;
    assign vs_rise = bus.lcd_vsync & ~vsync_q;
    assign vs_fall = ~bus.lcd_vsync & vsync_q;

    // Palette lookup uses the bgp value present in the accept cycle.
    assign shade = bus.bgp[{bus.lcd_color, 1'b0} +: 2];

    // Pixels beyond the end of the line are dropped; only the 4th pixel of a
    // group completes a byte, so partial bytes at a short line never write.
    assign pix_keep  = accept && (x != X_END);
    assign byte_done = pix_keep && (x[1:0] == 2'd3);
    assign line_bad  = line_end && ((x != X_END) || line_ovf);

    // On a simultaneous hsync/vsync rise the line check lands first, so the
    // frame check sees the incremented line count and that line's verdict.
    assign y_after  = line_end ? y + 1'b1 : y;
    assign frame_ok = (y_after == Y_END) && !frame_bad && !line_bad;

    // Previous sync levels for edge detection; vsync_seen blocks a low vsync
    // at reset release from reading as a fall and starting capture mid-frame.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments keep every register sampling the
        // pre-edge values, so process order can never change the result.
        if (rst) begin
            hsync_q    <= 1'b1;
            vsync_q    <= 1'b1;
            vsync_seen <= 1'b0;
        end else begin
            hsync_q    <= bus.lcd_hsync;
            vsync_q    <= bus.lcd_vsync;
            vsync_seen <= vsync_seen | bus.lcd_vsync;
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= S_SYNC;
        else     state <= state_next;
    end

    // Next-state logic; vsync events outrank hsync events.
    always_comb begin
        // NOTE: default assignment first, so no path leaves state_next
        // unassigned and no latch is inferred.
        state_next = state;
        case (state)
            S_SYNC:   if (vs_fall && vsync_seen) state_next = S_ACTIVE;
            S_ACTIVE: if (vs_rise)               state_next = S_VBLANK;
                      else if (hs_rise)          state_next = S_HBLANK;
            S_HBLANK: if (vs_rise)               state_next = S_VBLANK;
                      else if (hs_fall)          state_next = S_ACTIVE;
            S_VBLANK: if (vs_fall)               state_next = S_ACTIVE;
            default:                             state_next = S_SYNC;
        endcase
    end

    // Per-state decode of the events that move the datapath.
    always_comb begin
        accept      = (state == S_ACTIVE) && bus.lcd_pixel &&
                      !bus.lcd_hsync && !bus.lcd_vsync;
        line_end    = (state == S_ACTIVE) && hs_rise;
        frame_end   = ((state == S_ACTIVE) || (state == S_HBLANK)) && vs_rise;
        frame_start = ((state == S_SYNC) && vs_fall && vsync_seen) ||
                      ((state == S_VBLANK) && vs_fall);
    end

    // Line/frame counters, shade packing, bank swap and the write port.
    always_ff @(posedge clk) begin
        if (rst) begin
            x                <= '0;
            y                <= '0;
            line_base        <= '0;
            frame_bad        <= 1'b0;
            line_ovf         <= 1'b0;
            wr_bank          <= 1'b1;
            pack             <= '0;
            bus.fb_we        <= 1'b0;
            bus.fb_addr      <= '0;
            bus.fb_data      <= '0;
            bus.frame_ready  <= 1'b0;
            bus.line_err     <= 1'b0;
            bus.display_bank <= 1'b0;
        end else begin
            bus.fb_we       <= byte_done;
            bus.line_err    <= line_bad;
            bus.frame_ready <= frame_end && frame_ok;

            if (byte_done) begin
                bus.fb_data <= {pack, shade};
                bus.fb_addr <= {wr_bank, line_base + OW'(x[XW-1:2])};
            end

            if (accept) begin
                if (pix_keep) begin
                    x    <= x + 1'b1;
                    pack <= {pack[3:0], shade};
                end else begin
                    frame_bad <= 1'b1;
                    line_ovf  <= 1'b1;
                end
            end

            if (line_end) begin
                x         <= '0;
                y         <= y + 1'b1;
                line_base <= line_base + STRIDE;
                line_ovf  <= 1'b0;
                if (line_bad) frame_bad <= 1'b1;
            end

            if (frame_end && frame_ok) begin
                bus.display_bank <= wr_bank;
                wr_bank          <= ~wr_bank;
            end

            if (frame_start) begin
                x         <= '0;
                y         <= '0;
                line_base <= '0;
                frame_bad <= 1'b0;
                line_ovf  <= 1'b0;
            end
        end
    end
endmodule
